retry_resp_dispatch: RTL and testbench

- Sits directly downstream of the Retry Engine output and consumes its two streams:
  - the grant stream (vld_out_grant / grant_des_id / rdy_out_grant);
  - the response stream (vld_resp_out / payload_out / rdy_resp_out).
- Queues each stream independently, pairs them in arrival order (Nth grant with Nth payload), and delivers each payload to the destination named by its grant.
- Delivery uses a shared payload bus with a one-hot valid/ready handshake per destination.
- Provides bad-destination drop, an error counter and a stall watchdog.

---
 rtl/retry_dispatch_pkg.sv | 10 +
 rtl/retry_sync_fifo.sv | 60 ++++++
 rtl/retry_resp_dispatch.sv | 107 ++++++++++
 tb/tb_retry_resp_dispatch.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/retry_dispatch_pkg.sv
// Shared widths and types for the retry response dispatcher.
package retry_dispatch_pkg;
  // Payload width of the Retry Engine feeding this block.
  localparam int PAYLD_BW_DEF = 64;
  localparam int DEST_ID_W    = 4;
  localparam int ERR_CNT_W    = 8;
  localparam int STALL_CNT_W  = 8;

  typedef logic [DEST_ID_W-1:0] grant_t;
endpackage

// File: rtl/retry_sync_fifo.sv
// First-word-fall-through synchronous FIFO, occupancy-counted, power-of-two depth.
module retry_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]             cnt_q, cnt_d;
  logic                    do_push, do_pop;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    // A pop frees the slot, so a push into a full FIFO is fine in the same cycle.
    do_pop   = pop & !empty;
    do_push  = push & (!full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/retry_resp_dispatch.sv
// Pairs Retry Engine grants with responses in order and delivers each payload
// to the granted destination over a shared bus with one-hot valid/ready.
module retry_resp_dispatch
  import retry_dispatch_pkg::*;
#(
  parameter int PAYLD_BW  = PAYLD_BW_DEF,
  parameter int NUM_DEST  = 16,
  parameter int GNT_DEPTH = 4,
  parameter int PLD_DEPTH = 4,
  parameter int STALL_MAX = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vld_out_grant,
  input  logic [DEST_ID_W-1:0] grant_des_id,
  output logic                 rdy_out_grant,
  input  logic                 vld_resp_out,
  input  logic [PAYLD_BW-1:0]  payload_out,
  output logic                 rdy_resp_out,
  output logic [NUM_DEST-1:0]  dst_vld,
  input  logic [NUM_DEST-1:0]  dst_rdy,
  output logic [PAYLD_BW-1:0]  dst_payload,
  output logic                 err_bad_dest,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 stall_flag
);
  localparam logic [DEST_ID_W:0]   NUM_DEST_W  = (DEST_ID_W+1)'(NUM_DEST);
  localparam logic [STALL_CNT_W-1:0] STALL_MAX_W = STALL_CNT_W'(STALL_MAX);

  grant_t              g_head;
  logic [PAYLD_BW-1:0] p_head;
  logic                g_full, g_empty, p_full, p_empty;
  logic                pair_ok, load, bad, fire;
  logic [NUM_DEST-1:0] fire_vec;

  logic                   out_v_q, out_v_d;
  grant_t                 out_id_q, out_id_d;
  logic [PAYLD_BW-1:0]    out_pld_q, out_pld_d;
  logic                   err_bad_q, err_bad_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign rdy_out_grant = !g_full;
  assign rdy_resp_out  = !p_full;

  retry_sync_fifo #(.W(DEST_ID_W), .DEPTH(GNT_DEPTH)) u_gnt_fifo (
    .clk(clk), .rst(rst),
    .push(vld_out_grant & !g_full), .din(grant_des_id), .pop(load),
    .full(g_full), .empty(g_empty), .head(g_head)
  );

  retry_sync_fifo #(.W(PAYLD_BW), .DEPTH(PLD_DEPTH)) u_pld_fifo (
    .clk(clk), .rst(rst),
    .push(vld_resp_out & !p_full), .din(payload_out), .pop(load),
    .full(p_full), .empty(p_empty), .head(p_head)
  );

  for (genvar i = 0; i < NUM_DEST; i++) begin : g_dst
    assign dst_vld[i]  = out_v_q & (out_id_q == DEST_ID_W'(i));
    assign fire_vec[i] = dst_vld[i] & dst_rdy[i];
  end

  assign fire         = |fire_vec;
  assign dst_payload  = out_pld_q;
  assign err_bad_dest = err_bad_q;
  assign err_cnt      = err_cnt_q;
  assign stall_flag   = (stall_cnt_q == STALL_MAX_W);

  always_comb begin
    pair_ok   = !g_empty & !p_empty;
    load      = pair_ok & (!out_v_q | fire);
    bad       = ({1'b0, g_head} >= NUM_DEST_W);
    out_v_d   = out_v_q & !fire;
    out_id_d  = out_id_q;
    out_pld_d = out_pld_q;
    // A dropped pair leaves the output slot alone; only a good pair fills it.
    if (load & !bad) begin
      out_v_d   = 1'b1;
      out_id_d  = g_head;
      out_pld_d = p_head;
    end
    err_bad_d = load & bad;
    err_cnt_d = err_cnt_q;
    if (err_bad_d && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
    stall_cnt_d = stall_cnt_q;
    if (!out_v_q || fire)              stall_cnt_d = '0;
    else if (stall_cnt_q != STALL_MAX_W) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_v_q     <= 1'b0;
      out_id_q    <= '0;
      out_pld_q   <= '0;
      err_bad_q   <= 1'b0;
      err_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_v_q     <= out_v_d;
      out_id_q    <= out_id_d;
      out_pld_q   <= out_pld_d;
      err_bad_q   <= err_bad_d;
      err_cnt_q   <= err_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_retry_resp_dispatch.sv
// Directed bench for retry_resp_dispatch with a transaction-level pairing scoreboard.
module tb_retry_resp_dispatch;
  localparam int ND = 8;
  localparam int PW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vg = 1'b0, vp = 1'b0;
  logic [3:0]    gid = '0;
  logic [PW-1:0] pld = '0;
  logic          rdy_g, rdy_p, err_bad, stall;
  logic [ND-1:0] dst_vld, drdy = '1;
  logic [PW-1:0] dst_payload;
  logic [7:0]    err_cnt;

  always #5 clk = ~clk;

  retry_resp_dispatch #(.PAYLD_BW(PW), .NUM_DEST(ND), .GNT_DEPTH(4), .PLD_DEPTH(4),
                        .STALL_MAX(10)) dut (
    .clk(clk), .rst(rst),
    .vld_out_grant(vg), .grant_des_id(gid), .rdy_out_grant(rdy_g),
    .vld_resp_out(vp), .payload_out(pld), .rdy_resp_out(rdy_p),
    .dst_vld(dst_vld), .dst_rdy(drdy), .dst_payload(dst_payload),
    .err_bad_dest(err_bad), .err_cnt(err_cnt), .stall_flag(stall)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: accepted grants/payloads queue up, pair in order, bad ids vanish,
  // good pairs must show up on the bus in the same order.
  typedef struct { int id; logic [PW-1:0] pld; } del_t;
  logic [3:0]    gq[$];
  logic [PW-1:0] pq[$];
  del_t          expq[$];
  int            n_fire = 0, n_bad = 0;
  logic          hold_v = 1'b0;
  logic [ND-1:0] hold_vld;
  logic [PW-1:0] hold_pld;

  always @(negedge clk) begin : mon
    logic [ND-1:0] f;
    del_t          e;
    int            idx;
    logic [3:0]    g;
    logic [PW-1:0] p;
    if (rst) begin
      gq.delete(); pq.delete(); expq.delete();
      hold_v = 1'b0;
    end else begin
      f = dst_vld & drdy;
      if (hold_v) begin
        chk("hold_vld", 64'(dst_vld), 64'(hold_vld));
        chk("hold_pld", dst_payload, hold_pld);
      end
      if (dst_vld != '0) chk("onehot", 64'($countones(dst_vld)), 64'd1);
      if (f != '0) begin
        n_fire++;
        idx = 0;
        for (int i = 0; i < ND; i++) if (f[i]) idx = i;
        if (expq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_delivery dst=%0d pld=%0h expected=none", idx, dst_payload);
        end else begin
          e = expq.pop_front();
          chk("del_id", 64'(idx), 64'(e.id));
          chk("del_pld", dst_payload, e.pld);
        end
      end
      hold_v   = (dst_vld != '0) && (f == '0);
      hold_vld = dst_vld;
      hold_pld = dst_payload;
      if (vg && rdy_g) gq.push_back(gid);
      if (vp && rdy_p) pq.push_back(pld);
      while (gq.size() > 0 && pq.size() > 0) begin
        g = gq.pop_front();
        p = pq.pop_front();
        if (int'(g) < ND) expq.push_back('{int'(g), p});
        else n_bad++;
      end
    end
  end

  int sent, base, nb0;
  logic acc;
  int ids[4] = '{1, 2, 3, 6};

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_dst_vld", 64'(dst_vld), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_err_bad", 64'(err_bad), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    rst = 1'b0;
    tick();
    chk("rst_rdy_g", 64'(rdy_g), 64'd1);
    chk("rst_rdy_p", 64'(rdy_p), 64'd1);

    // Single pair: visible two cycles after acceptance, for one cycle
    vg = 1; gid = 4'd3; vp = 1; pld = 64'hA5A5;
    tick();
    vg = 0; vp = 0;
    chk("t1_t1_vld", 64'(dst_vld), 64'd0);
    tick();
    chk("t1_t2_vld", 64'(dst_vld), 64'h08);
    chk("t1_t2_pld", dst_payload, 64'hA5A5);
    tick();
    chk("t1_t3_vld", 64'(dst_vld), 64'd0);

    // Skewed arrival
    for (int c = 0; c <= 10; c++) begin
      vg  = (c < 2);
      gid = 4'(c + 1);
      vp  = (c == 6 || c == 7);
      pld = (c == 6) ? 64'h11 : 64'h22;
      if (c < 8)  chk("t2_idle", 64'(dst_vld), 64'd0);
      if (c == 8) begin chk("t2_d1_vld", 64'(dst_vld), 64'h02); chk("t2_d1_pld", dst_payload, 64'h11); end
      if (c == 9) begin chk("t2_d2_vld", 64'(dst_vld), 64'h04); chk("t2_d2_pld", dst_payload, 64'h22); end
      if (c == 10) chk("t2_done", 64'(dst_vld), 64'd0);
      tick();
    end
    vg = 0; vp = 0;

    // Backpressure: 4 queued + 1 held before readies drop
    drdy = '0; sent = 0; base = n_fire;
    for (int c = 0; c < 8; c++) begin
      vg = (sent < 6); vp = (sent < 6);
      gid = 4'(sent); pld = 64'h100 + 64'(sent);
      chk("t3_rdy_g", 64'(rdy_g), (c < 5) ? 64'd1 : 64'd0);
      chk("t3_rdy_p", 64'(rdy_p), (c < 5) ? 64'd1 : 64'd0);
      if (c == 7) begin
        chk("t3_held_vld", 64'(dst_vld), 64'h01);
        chk("t3_held_pld", dst_payload, 64'h100);
      end
      acc = vg && rdy_g;
      tick();
      if (acc) sent++;
    end
    chk("t3_sent5", 64'(sent), 64'd5);
    drdy = '1;
    for (int c = 0; c < 20; c++) begin
      vg = (sent < 6); vp = (sent < 6);
      gid = 4'(sent); pld = 64'h100 + 64'(sent);
      acc = vg && rdy_g;
      tick();
      if (acc) sent++;
    end
    vg = 0; vp = 0;
    chk("t3_sent6", 64'(sent), 64'd6);
    chk("t3_fires", 64'(n_fire - base), 64'd6);
    chk("t3_drained", 64'(expq.size()), 64'd0);

    // Bad destination
    nb0 = n_bad;
    vg = 1; vp = 1; gid = 4'd9; pld = 64'hDEAD;
    tick();
    gid = 4'd4; pld = 64'hBEEF;
    chk("t4_t1_err", 64'(err_bad), 64'd0);
    tick();
    vg = 0; vp = 0;
    chk("t4_t2_err", 64'(err_bad), 64'd1);
    chk("t4_t2_cnt", 64'(err_cnt), 64'd1);
    chk("t4_t2_vld", 64'(dst_vld), 64'd0);
    tick();
    chk("t4_t3_vld", 64'(dst_vld), 64'h10);
    chk("t4_t3_pld", dst_payload, 64'hBEEF);
    chk("t4_t3_err", 64'(err_bad), 64'd0);
    chk("t4_t3_cnt", 64'(err_cnt), 64'd1);
    tick();
    chk("t4_model_bad", 64'(n_bad - nb0), 64'd1);

    // Stall watchdog (STALL_MAX=10)
    drdy = 8'hDF;
    vg = 1; vp = 1; gid = 4'd5; pld = 64'h55;
    tick();
    vg = 0; vp = 0;
    tick();
    for (int k = 0; k <= 13; k++) begin
      if (k == 12) drdy = '1;
      chk("t5_stall", 64'(stall), (k >= 10 && k <= 12) ? 64'd1 : 64'd0);
      chk("t5_vld", 64'(dst_vld), (k <= 12) ? 64'h20 : 64'd0);
      tick();
    end

    // Reset mid-operation: 1 held + 3 queued, all discarded
    drdy = '0;
    for (int i = 0; i < 4; i++) begin
      vg = 1; vp = 1; gid = 4'(ids[i]); pld = 64'h600 + 64'(i);
      tick();
    end
    vg = 0; vp = 0;
    tick();
    chk("t6_held_vld", 64'(dst_vld), 64'h02);
    chk("t6_held_pld", dst_payload, 64'h600);
    rst = 1'b1;
    tick();
    chk("t6_vld", 64'(dst_vld), 64'd0);
    chk("t6_err_cnt", 64'(err_cnt), 64'd0);
    chk("t6_stall", 64'(stall), 64'd0);
    chk("t6_rdy_g", 64'(rdy_g), 64'd1);
    chk("t6_rdy_p", 64'(rdy_p), 64'd1);
    rst = 1'b0; drdy = '1; base = n_fire;
    repeat (10) tick();
    chk("t6_no_deliv", 64'(n_fire - base), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
